// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types and constants.
// Address bit numbering follows the core: bit 0 is the MSB, so "bits [0:31]" is [63:32] here.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_FETCH_ADDR = 64'h0;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        DROP,
        HOLD,
        ERR
    } fetch_state_e;

    // 32b mode clears the upper word at the moment an address is latched.
    function automatic logic [ADDR_W-1:0] mask_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic              mode32);
        mask_addr = mode32 ? {{(ADDR_W-32){1'b0}}, addr[31:0]} : addr;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, holds the fetched instruction
// for decode, redirects on flush and parks in an absorbing error state on any fault.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_32b_mode,
    input  logic [ADDR_W-1:0]  i_next_instr_addr,
    output logic               o_stall,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_flush_addr,
    output logic               o_mem_req_valid,
    input  logic               i_mem_req_ready,
    output logic [ADDR_W-1:0]  o_mem_req_addr,
    input  logic               i_mem_rsp_valid,
    input  logic [INSTR_W-1:0] i_mem_rsp_data,
    input  logic               i_mem_rsp_err,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_addr,
    input  logic               i_instr_ready,
    output logic               o_fetch_err
);

    fetch_state_e       state_q;
    logic               req_valid_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_addr_q;
    logic               fetch_err_q;
    logic               pend_q;
    logic [ADDR_W-1:0]  pend_addr_q;

    logic               launch;
    logic               proto_err;
    logic               rsp_fault;
    logic               to_err;
    logic [ADDR_W-1:0]  tgt_raw;
    logic [ADDR_W-1:0]  tgt;

    // launch: this edge starts a new request at tgt (unless tgt is misaligned).
    always_comb begin
        launch    = 1'b0;
        proto_err = 1'b0;
        rsp_fault = 1'b0;
        tgt_raw   = RESET_FETCH_ADDR;
        unique case (state_q)
            BOOT: begin
                proto_err = i_mem_rsp_valid;
                launch    = 1'b1;
                if (i_flush) tgt_raw = i_flush_addr;
            end
            REQ: proto_err = i_mem_rsp_valid;
            WAIT: begin
                if (i_mem_rsp_valid) begin
                    if (i_flush) begin
                        launch  = 1'b1;
                        tgt_raw = i_flush_addr;
                    end else begin
                        rsp_fault = i_mem_rsp_err;
                    end
                end
            end
            DROP: begin
                if (i_mem_rsp_valid) begin
                    launch  = 1'b1;
                    tgt_raw = i_flush ? i_flush_addr : pend_addr_q;
                end
            end
            HOLD: begin
                proto_err = i_mem_rsp_valid;
                if (i_flush) begin
                    launch  = 1'b1;
                    tgt_raw = i_flush_addr;
                end else if (i_instr_ready) begin
                    launch  = 1'b1;
                    tgt_raw = i_next_instr_addr;
                end
            end
            default: ;
        endcase
        tgt    = mask_addr(tgt_raw, i_32b_mode);
        to_err = proto_err | rsp_fault | (launch & (tgt[1:0] != 2'b00));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= BOOT;
            req_valid_q   <= 1'b0;
            req_addr_q    <= RESET_FETCH_ADDR;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            fetch_err_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_addr_q   <= '0;
        end else if (to_err) begin
            state_q       <= ERR;
            fetch_err_q   <= 1'b1;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            pend_q        <= 1'b0;
        end else if (launch) begin
            state_q       <= REQ;
            req_valid_q   <= 1'b1;
            req_addr_q    <= tgt;
            instr_valid_q <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    // A presented request is never withdrawn; a flush only arms the drop.
                    if (i_flush) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= mask_addr(i_flush_addr, i_32b_mode);
                    end
                    if (i_mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (pend_q || i_flush) ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_rsp_valid) begin
                        instr_q       <= i_mem_rsp_data;
                        instr_addr_q  <= req_addr_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end else if (i_flush) begin
                        pend_q      <= 1'b1;
                        pend_addr_q <= mask_addr(i_flush_addr, i_32b_mode);
                        state_q     <= DROP;
                    end
                end
                DROP: begin
                    if (i_flush) pend_addr_q <= mask_addr(i_flush_addr, i_32b_mode);
                end
                default: ;
            endcase
        end
    end

    assign o_mem_req_valid = req_valid_q;
    assign o_mem_req_addr  = req_addr_q;
    assign o_instr_valid   = instr_valid_q;
    assign o_instr         = instr_q;
    assign o_instr_addr    = instr_addr_q;
    assign o_fetch_err     = fetch_err_q;
    assign o_stall         = !(instr_valid_q && i_instr_ready);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level model queues the expected request
// addresses and decoded instructions; a monitor pops them as the DUT presents each one.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_32b_mode = 1'b0;
    logic [ADDR_W-1:0]  i_next_instr_addr = '0;
    logic               o_stall;
    logic               i_flush = 1'b0;
    logic [ADDR_W-1:0]  i_flush_addr = '0;
    logic               o_mem_req_valid;
    logic               i_mem_req_ready = 1'b0;
    logic [ADDR_W-1:0]  o_mem_req_addr;
    logic               i_mem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] i_mem_rsp_data = '0;
    logic               i_mem_rsp_err = 1'b0;
    logic               o_instr_valid;
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_instr_addr;
    logic               i_instr_ready = 1'b0;
    logic               o_fetch_err;

    always #5 i_clk = ~i_clk;

    fetch_sequencer dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_32b_mode        (i_32b_mode),
        .i_next_instr_addr (i_next_instr_addr),
        .o_stall           (o_stall),
        .i_flush           (i_flush),
        .i_flush_addr      (i_flush_addr),
        .o_mem_req_valid   (o_mem_req_valid),
        .i_mem_req_ready   (i_mem_req_ready),
        .o_mem_req_addr    (o_mem_req_addr),
        .i_mem_rsp_valid   (i_mem_rsp_valid),
        .i_mem_rsp_data    (i_mem_rsp_data),
        .i_mem_rsp_err     (i_mem_rsp_err),
        .o_instr_valid     (o_instr_valid),
        .o_instr           (o_instr),
        .o_instr_addr      (o_instr_addr),
        .i_instr_ready     (i_instr_ready),
        .o_fetch_err       (o_fetch_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus knobs for the next cycle.
    bit          d_ready, d_flush, d_iready, d_mode, d_err;
    logic [63:0] d_flush_addr, d_next;
    logic [31:0] d_data;
    int          d_lat;

    // Reference model: what the fetch unit is doing after the coming edge.
    bit          m_boot, m_pres, m_out, m_hold, m_err, m_disc;
    logic [63:0] m_pend, m_cur;
    logic [63:0] exp_req_q[$];
    logic [95:0] exp_instr_q[$];

    // Memory model.
    bit mem_busy;
    int mem_cnt;

    bit mon_en = 1'b0;
    bit prev_req, prev_instr;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    function automatic logic [63:0] msk(input logic [63:0] a);
        return d_mode ? {32'h0, a[31:0]} : a;
    endfunction

    task automatic start_fetch(input logic [63:0] a);
        logic [63:0] t;
        t = msk(a);
        if (t[1:0] != 2'b00) begin
            m_err = 1'b1;
        end else begin
            exp_req_q.push_back(t);
            m_pres = 1'b1;
            m_cur  = t;
        end
    endtask

    // Drive one cycle of inputs and advance the model across the coming rising edge.
    task automatic step();
        bit rv;
        rv = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rv       = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (o_mem_req_valid && d_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = d_lat;
        end
        i_mem_req_ready   = d_ready;
        i_mem_rsp_valid   = rv;
        i_mem_rsp_data    = d_data;
        i_mem_rsp_err     = rv & d_err;
        i_flush           = d_flush;
        i_flush_addr      = d_flush_addr;
        i_instr_ready     = d_iready;
        i_next_instr_addr = d_next;
        i_32b_mode        = d_mode;

        if (!m_err) begin
            if (m_boot) begin
                m_boot = 1'b0;
                start_fetch(d_flush ? d_flush_addr : 64'h0);
            end else if (m_pres) begin
                if (d_flush) begin
                    m_disc = 1'b1;
                    m_pend = msk(d_flush_addr);
                end
                if (d_ready) begin
                    m_pres = 1'b0;
                    m_out  = 1'b1;
                end
            end else if (m_out) begin
                if (rv) begin
                    m_out = 1'b0;
                    if (m_disc || d_flush) begin
                        m_disc = 1'b0;
                        start_fetch(d_flush ? d_flush_addr : m_pend);
                    end else if (d_err) begin
                        m_err = 1'b1;
                    end else begin
                        exp_instr_q.push_back({m_cur, d_data});
                        m_hold = 1'b1;
                    end
                end else if (d_flush) begin
                    m_disc = 1'b1;
                    m_pend = msk(d_flush_addr);
                end
            end else if (m_hold) begin
                if (d_flush) begin
                    m_hold = 1'b0;
                    start_fetch(d_flush_addr);
                end else if (d_iready) begin
                    m_hold = 1'b0;
                    start_fetch(d_next);
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
            step();
        end
    endtask

    task automatic set_defaults();
        d_ready = 1; d_flush = 0; d_iready = 1; d_mode = 0; d_err = 0;
        d_flush_addr = '0; d_next = '0; d_data = '0; d_lat = 0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge i_clk);
        #1;
        i_rst = 1'b1;
        i_mem_rsp_valid = 1'b0;
        i_flush = 1'b0;
        i_instr_ready = 1'b0;
        m_boot = 0; m_pres = 0; m_out = 0; m_hold = 0; m_err = 0; m_disc = 0;
        m_pend = '0; m_cur = '0;
        exp_req_q.delete();
        exp_instr_q.delete();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        repeat (2) @(negedge i_clk);
        check("rst_req_valid", 64'(o_mem_req_valid), 64'h0);
        check("rst_req_addr", o_mem_req_addr, 64'h0);
        check("rst_instr_valid", 64'(o_instr_valid), 64'h0);
        check("rst_instr", 64'(o_instr), 64'h0);
        check("rst_instr_addr", o_instr_addr, 64'h0);
        check("rst_fetch_err", 64'(o_fetch_err), 64'h0);
        check("rst_stall", 64'(o_stall), 64'h1);
        #1;
        i_rst = 1'b0;
        m_boot = 1'b1;
        step();
        prev_req   = 1'b0;
        prev_instr = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic wait_model(input bit want_hold, input int budget, input string name);
        int k;
        k = 0;
        while (!(want_hold ? m_hold : m_out) && k < budget) begin
            run(1);
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            $display("FAIL %s: got no such phase within %0d cycles, want it reached", name, budget);
        end
    endtask

    // Monitor: per-cycle control checks and scoreboard pops on each new presentation.
    initial begin
        logic [63:0] want_a;
        logic [95:0] want_i;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                check("req_valid", 64'(o_mem_req_valid), 64'(m_pres));
                check("instr_valid", 64'(o_instr_valid), 64'(m_hold));
                check("fetch_err", 64'(o_fetch_err), 64'(m_err));
                check("stall", 64'(o_stall), 64'(!(m_hold && i_instr_ready)));
                if (o_mem_req_valid) begin
                    if (!prev_req) begin
                        if (exp_req_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL req_unexpected: got request %h, want none", o_mem_req_addr);
                        end else begin
                            want_a = exp_req_q.pop_front();
                            check("req_addr", o_mem_req_addr, want_a);
                        end
                    end else begin
                        check("req_addr_stable", o_mem_req_addr, m_cur);
                    end
                end
                if (o_instr_valid && !prev_instr) begin
                    if (exp_instr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL instr_unexpected: got instr %h, want none", o_instr);
                    end else begin
                        want_i = exp_instr_q.pop_front();
                        check("instr_data", 64'(o_instr), 64'(want_i[31:0]));
                        check("instr_addr", o_instr_addr, want_i[95:32]);
                    end
                end
                prev_req   = o_mem_req_valid;
                prev_instr = o_instr_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Zero-wait memory, branch instruction, decode always ready.
        set_defaults();
        d_data = 32'h4800_0010;
        d_next = 64'h10;
        do_reset();
        run(8);

        // Memory not ready for four cycles: request must hold steady.
        set_defaults();
        d_ready = 0;
        d_next  = 64'h40;
        do_reset();
        run(4);
        d_ready = 1;
        run(6);

        // Flush while the request is outstanding: response dropped, refetch from 0x700.
        set_defaults();
        d_lat  = 2;
        d_next = 64'h10;
        d_data = 32'h6000_0000;
        do_reset();
        wait_model(1'b0, 10, "reach_outstanding");
        d_flush = 1; d_flush_addr = 64'h700;
        run(1);
        d_flush = 0;
        run(12);

        // Flush coincident with decode handshake wins over the branch address.
        set_defaults();
        d_iready = 0;
        d_next   = 64'h20;
        d_data   = 32'h1234_5678;
        do_reset();
        wait_model(1'b1, 10, "reach_hold");
        d_flush = 1; d_flush_addr = 64'h900; d_iready = 1;
        run(1);
        d_flush = 0;
        run(6);

        // Access error response is sticky and stops fetching.
        set_defaults();
        d_err = 1;
        do_reset();
        run(8);

        // Misaligned next address: error, no request.
        set_defaults();
        d_next = 64'h6;
        do_reset();
        run(8);

        // 32b mode clears the upper word of the latched address.
        set_defaults();
        d_mode = 1;
        d_next = 64'hFFFF_FFFF_0000_0040;
        do_reset();
        run(8);

        // Randomized traffic, once per addressing mode, then drain.
        for (int ph = 0; ph < 2; ph++) begin
            set_defaults();
            d_mode = ph[0];
            do_reset();
            repeat (400) begin
                d_ready      = ($urandom_range(0, 3) != 0);
                d_flush      = ($urandom_range(0, 9) == 0);
                d_flush_addr = {$urandom, $urandom} & ~64'h3;
                d_iready     = $urandom_range(0, 1) == 1;
                d_next       = {$urandom, $urandom} & ~64'h3;
                d_data       = $urandom;
                d_lat        = $urandom_range(0, 3);
                run(1);
            end
            d_flush = 0; d_iready = 0; d_ready = 1; d_lat = 0;
            run(12);
            check("drain_req_q", 64'(exp_req_q.size()), 64'h0);
            check("drain_instr_q", 64'(exp_instr_q.size()), 64'h0);
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
